// File: rtl/wb_port_arbiter_pkg.sv
// +----------------------------------------------------------------------------
// | wb_port_arbiter_pkg : shared constants and select helper for the write-port arbiter
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

package wb_port_arbiter_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int REG_AW_DEF = 3;

    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC  = 2'b10;

    // The link value has priority over load data when both controls are raised.
    function automatic logic [1:0] wb_sel_of(input logic mem_to_reg, input logic jal_en);
        if (jal_en)
            return WB_SEL_PC;
        else if (mem_to_reg)
            return WB_SEL_MEM;
        else
            return WB_SEL_ALU;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_req_buf.sv
// +----------------------------------------------------------------------------
// | wb_req_buf : one-entry valid/ready holding register for a write request
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module wb_req_buf
    import wb_port_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [REG_AW-1:0] push_dst,
    input  logic [DATA_W-1:0] push_data,
    input  logic [1:0]        push_sel,
    input  logic              pop,
    output logic              full,
    output logic [REG_AW-1:0] dst,
    output logic [DATA_W-1:0] data,
    output logic [1:0]        sel
);

    // A granted entry drains at the same edge, so it may be refilled in that cycle.
    assign push_ready = !full || pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 1'b0;
            dst  <= '0;
            data <= '0;
            sel  <= WB_SEL_ALU;
        end else if (push_valid && push_ready) begin
            full <= 1'b1;
            dst  <= push_dst;
            data <= push_data;
            sel  <= push_sel;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_port_arbiter.sv
// +----------------------------------------------------------------------------
// | wb_port_arbiter : register-file write-port arbiter between pipeline writeback and late loads
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_AW     = REG_AW_DEF,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [REG_AW-1:0] a_dst,
    input  logic [DATA_W-1:0] a_alu,
    input  logic [DATA_W-1:0] a_mem,
    input  logic [DATA_W-1:0] a_pcn,
    input  logic              a_memToReg,
    input  logic              a_JAL_en,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [REG_AW-1:0] b_dst,
    input  logic [DATA_W-1:0] b_data,
    output logic              rf_wr_en,
    output logic [REG_AW-1:0] rf_wr_reg,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic [1:0]        wb_sel,
    output logic              sel_err
);

    localparam int               CNT_W   = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [1:0]        a_in_sel;
    logic [DATA_W-1:0] a_in_data;

    logic              a_full,  b_full;
    logic [REG_AW-1:0] a_q_dst, b_q_dst;
    logic [DATA_W-1:0] a_q_data, b_q_data;
    logic [1:0]        a_q_sel;
    logic [1:0]        unused_b_sel;

    logic              grant_a, grant_b;
    logic [CNT_W-1:0]  starve_cnt;

    // Only the selected word is buffered; the raw ALU/mem/PC inputs are dropped here.
    always_comb begin
        a_in_sel = wb_sel_of(a_memToReg, a_JAL_en);
        case (a_in_sel)
            WB_SEL_PC:  a_in_data = a_pcn;
            WB_SEL_MEM: a_in_data = a_mem;
            default:    a_in_data = a_alu;
        endcase
    end

    wb_req_buf #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_a_buf (
        .clk        (clk),
        .rst        (rst),
        .push_valid (a_valid),
        .push_ready (a_ready),
        .push_dst   (a_dst),
        .push_data  (a_in_data),
        .push_sel   (a_in_sel),
        .pop        (grant_a),
        .full       (a_full),
        .dst        (a_q_dst),
        .data       (a_q_data),
        .sel        (a_q_sel)
    );

    wb_req_buf #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_b_buf (
        .clk        (clk),
        .rst        (rst),
        .push_valid (b_valid),
        .push_ready (b_ready),
        .push_dst   (b_dst),
        .push_data  (b_data),
        .push_sel   (WB_SEL_MEM),
        .pop        (grant_b),
        .full       (b_full),
        .dst        (b_q_dst),
        .data       (b_q_data),
        .sel        (unused_b_sel)
    );

    // The older load wins unless A has starved long enough; a shared destination
    // always lets B go first so the younger A value is the one that survives.
    always_comb begin
        grant_b = b_full && !(a_full && (starve_cnt == CNT_MAX) && (a_q_dst != b_q_dst));
        grant_a = a_full && !grant_b;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (a_full && b_full && grant_b) begin
            if (starve_cnt != CNT_MAX)
                starve_cnt <= starve_cnt + CNT_W'(1);
        end else begin
            starve_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wr_en   <= 1'b0;
            rf_wr_reg  <= '0;
            rf_wr_data <= '0;
            wb_sel     <= WB_SEL_ALU;
            sel_err    <= 1'b0;
        end else begin
            rf_wr_en <= grant_a || grant_b;
            if (grant_b) begin
                rf_wr_reg  <= b_q_dst;
                rf_wr_data <= b_q_data;
            end else if (grant_a) begin
                rf_wr_reg  <= a_q_dst;
                rf_wr_data <= a_q_data;
                wb_sel     <= a_q_sel;
            end
            if (a_valid && a_ready && a_memToReg && a_JAL_en)
                sel_err <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
// +----------------------------------------------------------------------------
// | tb_wb_port_arbiter : directed self-checking bench for wb_port_arbiter
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module tb_wb_port_arbiter;

    logic        clk;
    logic        rst;
    logic        a_valid, a_ready;
    logic [2:0]  a_dst;
    logic [15:0] a_alu, a_mem, a_pcn;
    logic        a_memToReg, a_JAL_en;
    logic        b_valid, b_ready;
    logic [2:0]  b_dst;
    logic [15:0] b_data;
    logic        rf_wr_en;
    logic [2:0]  rf_wr_reg;
    logic [15:0] rf_wr_data;
    logic [1:0]  wb_sel;
    logic        sel_err;

    int checks = 0;
    int errors = 0;

    wb_port_arbiter #(.DATA_W(16), .REG_AW(3), .STARVE_MAX(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_dst      (a_dst),
        .a_alu      (a_alu),
        .a_mem      (a_mem),
        .a_pcn      (a_pcn),
        .a_memToReg (a_memToReg),
        .a_JAL_en   (a_JAL_en),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_dst      (b_dst),
        .b_data     (b_data),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_reg  (rf_wr_reg),
        .rf_wr_data (rf_wr_data),
        .wb_sel     (wb_sel),
        .sel_err    (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_a(input logic v, input logic [2:0] d, input logic [15:0] alu,
                         input logic [15:0] mem, input logic [15:0] pcn,
                         input logic m2r, input logic jal);
        a_valid    = v;
        a_dst      = d;
        a_alu      = alu;
        a_mem      = mem;
        a_pcn      = pcn;
        a_memToReg = m2r;
        a_JAL_en   = jal;
    endtask

    task automatic check_wr(input string tag, input logic [2:0] r, input logic [15:0] d);
        check({tag, "_en"},   32'(rf_wr_en),   32'h1);
        check({tag, "_reg"},  32'(rf_wr_reg),  32'(r));
        check({tag, "_data"}, 32'(rf_wr_data), 32'(d));
    endtask

    initial begin
        rst = 1'b1;
        set_a(1'b0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        b_valid = 1'b0;
        b_dst   = 3'd0;
        b_data  = 16'h0;

        // Reset state
        #3;
        check("rst_wr_en",   32'(rf_wr_en),   32'h0);
        check("rst_wr_reg",  32'(rf_wr_reg),  32'h0);
        check("rst_wr_data", 32'(rf_wr_data), 32'h0);
        check("rst_wb_sel",  32'(wb_sel),     32'h0);
        check("rst_sel_err", 32'(sel_err),    32'h0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_a_ready", 32'(a_ready), 32'h1);
        check("rst_b_ready", 32'(b_ready), 32'h1);

        // Plain ALU write: one edge after capture
        set_a(1'b1, 3'd3, 16'h1234, 16'hDEAD, 16'hBEEF, 1'b0, 1'b0);
        tick();
        a_valid = 1'b0;
        check("t1_no_wr_yet", 32'(rf_wr_en), 32'h0);
        tick();
        check_wr("t1", 3'd3, 16'h1234);
        check("t1_sel", 32'(wb_sel), 32'h0);
        tick();
        check("t1_idle", 32'(rf_wr_en), 32'h0);

        // JAL link value, then the conflicting-control case
        set_a(1'b1, 3'd1, 16'h1111, 16'h2222, 16'h0042, 1'b0, 1'b1);
        tick();
        a_valid = 1'b0;
        tick();
        check_wr("t2_jal", 3'd1, 16'h0042);
        check("t2_jal_sel", 32'(wb_sel),  32'h2);
        check("t2_no_err",  32'(sel_err), 32'h0);
        set_a(1'b1, 3'd6, 16'h1111, 16'h5555, 16'h0077, 1'b1, 1'b1);
        tick();
        a_valid = 1'b0;
        check("t2_err_set", 32'(sel_err), 32'h1);
        tick();
        check_wr("t2_both", 3'd6, 16'h0077);
        check("t2_both_sel", 32'(wb_sel), 32'h2);
        tick();
        tick();
        check("t2_err_sticky", 32'(sel_err), 32'h1);

        // Simultaneous A and B: B first, A next cycle
        set_a(1'b1, 3'd2, 16'hAAAA, 16'h0, 16'h0, 1'b0, 1'b0);
        b_valid = 1'b1; b_dst = 3'd5; b_data = 16'hBBBB;
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        check("t3_a_ready_lo", 32'(a_ready),  32'h0);
        check("t3_b_ready",    32'(b_ready),  32'h1);
        check("t3_no_wr",      32'(rf_wr_en), 32'h0);
        tick();
        check_wr("t3_b", 3'd5, 16'hBBBB);
        check("t3_sel_held",  32'(wb_sel),  32'h2);
        check("t3_a_ready_hi", 32'(a_ready), 32'h1);
        tick();
        check_wr("t3_a", 3'd2, 16'hAAAA);
        check("t3_a_sel", 32'(wb_sel), 32'h0);
        tick();
        check("t3_idle", 32'(rf_wr_en), 32'h0);

        // Back-to-back A, memToReg path, one write per cycle
        set_a(1'b1, 3'd1, 16'h0, 16'h0101, 16'h0, 1'b1, 1'b0);
        tick();
        check("tp_ready0", 32'(a_ready), 32'h1);
        set_a(1'b1, 3'd2, 16'h0, 16'h0202, 16'h0, 1'b1, 1'b0);
        tick();
        check_wr("tp0", 3'd1, 16'h0101);
        check("tp_sel", 32'(wb_sel), 32'h1);
        check("tp_ready1", 32'(a_ready), 32'h1);
        set_a(1'b1, 3'd3, 16'h0, 16'h0303, 16'h0, 1'b1, 1'b0);
        tick();
        check_wr("tp1", 3'd2, 16'h0202);
        check("tp_ready2", 32'(a_ready), 32'h1);
        a_valid = 1'b0;
        tick();
        check_wr("tp2", 3'd3, 16'h0303);
        tick();

        // Starvation: distinct dst, A wins on its 4th contested cycle
        set_a(1'b1, 3'd1, 16'hA4A4, 16'h0, 16'h0, 1'b0, 1'b0);
        b_valid = 1'b1; b_dst = 3'd5; b_data = 16'hB000;
        tick();
        a_valid = 1'b0;
        b_data = 16'hB001;
        tick();
        check_wr("t4_b0", 3'd5, 16'hB000);
        check("t4_a_wait", 32'(a_ready), 32'h0);
        b_data = 16'hB002;
        tick();
        check_wr("t4_b1", 3'd5, 16'hB001);
        b_data = 16'hB003;
        tick();
        check_wr("t4_b2", 3'd5, 16'hB002);
        check("t4_b_blocked", 32'(b_ready), 32'h0);
        check("t4_a_granted", 32'(a_ready), 32'h1);
        b_data = 16'hB004;
        tick();
        check_wr("t4_a", 3'd1, 16'hA4A4);
        check("t4_cnt_clr", 32'(dut.starve_cnt), 32'h0);
        tick();
        b_valid = 1'b0;
        check_wr("t4_b3", 3'd5, 16'hB003);
        tick();
        check_wr("t4_b4", 3'd5, 16'hB004);
        tick();
        check("t4_idle", 32'(rf_wr_en), 32'h0);

        // Same destination at saturation: B keeps priority, A lands last
        set_a(1'b1, 3'd4, 16'hA5A5, 16'h0, 16'h0, 1'b0, 1'b0);
        b_valid = 1'b1; b_dst = 3'd4; b_data = 16'hC000;
        tick();
        a_valid = 1'b0;
        b_data = 16'hC001;
        tick();
        check_wr("t5_b0", 3'd4, 16'hC000);
        b_data = 16'hC002;
        tick();
        check_wr("t5_b1", 3'd4, 16'hC001);
        b_data = 16'hC003;
        tick();
        check_wr("t5_b2", 3'd4, 16'hC002);
        check("t5_cnt_max", 32'(dut.starve_cnt), 32'h3);
        check("t5_b_still", 32'(b_ready), 32'h1);
        b_data = 16'hC004;
        tick();
        check_wr("t5_b3", 3'd4, 16'hC003);
        check("t5_a_held", 32'(a_ready), 32'h0);
        b_valid = 1'b0;
        tick();
        check_wr("t5_b4", 3'd4, 16'hC004);
        tick();
        check_wr("t5_a_last", 3'd4, 16'hA5A5);
        tick();
        check("t5_idle", 32'(rf_wr_en), 32'h0);

        // Reset mid-operation with both buffers full
        set_a(1'b1, 3'd7, 16'h7777, 16'h0, 16'h0, 1'b0, 1'b0);
        b_valid = 1'b1; b_dst = 3'd3; b_data = 16'h3333;
        tick();
        a_valid = 1'b0;
        b_data = 16'h3334;
        tick();
        check_wr("t6_b", 3'd3, 16'h3333);
        rst = 1'b1;
        #1;
        check("t6_async_en", 32'(rf_wr_en),  32'h0);
        check("t6_async_reg", 32'(rf_wr_reg), 32'h0);
        check("t6_a_ready",  32'(a_ready),   32'h1);
        check("t6_b_ready",  32'(b_ready),   32'h1);
        b_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("t6_no_wr0", 32'(rf_wr_en), 32'h0);
        tick();
        check("t6_no_wr1",  32'(rf_wr_en),   32'h0);
        check("t6_data",    32'(rf_wr_data), 32'h0);
        check("t6_err_clr", 32'(sel_err),    32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Owns the single register-file write port. It arbitrates between two requesters:
- requester A: the in-order pipeline writeback stage, which supplies aluOutput, readData and PC_Next plus the memToReg and JAL_en controls;
- requester B: the multicycle memory unit, which returns late load data.
Each requester has a one-entry holding buffer and a valid/ready handshake. The block generates the writeback mux select, orders same-destination writes, and prevents starvation of A.

Parameters:
DATA_W, 16, register data width
REG_AW, 3, register-address width (8 GPRs)
STARVE_MAX, 3, consecutive cycles A may lose arbitration before it is forced to win

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
a_valid  in  1  pipeline writeback request
a_ready  out  1  A buffer can accept this cycle
a_dst  in  REG_AW  destination register
a_alu  in  DATA_W  ALU result
a_mem  in  DATA_W  load data read by the pipeline
a_pcn  in  DATA_W  PC_Next (link value)
a_memToReg  in  1  select load data
a_JAL_en  in  1  select link value
b_valid  in  1  late-load return request
b_ready  out  1  B buffer can accept this cycle
b_dst  in  REG_AW  destination register
b_data  in  DATA_W  returned load data
rf_wr_en  out  1  register-file write strobe
rf_wr_reg  out  REG_AW  write address
rf_wr_data  out  DATA_W  write data
wb_sel  out  2  select used for the granted A write: 00 ALU, 01 mem, 10 PC_Next
sel_err  out  1  sticky flag: memToReg and JAL_en were both set on an accepted A request

Behaviour:
- Reset (async, rst=1): both buffers EMPTY, starve_cnt=0, rf_wr_en=0, rf_wr_reg=0, rf_wr_data=0, wb_sel=00, sel_err=0. a_ready and b_ready read 1 once rst is deasserted.
- Handshake:
  - A transfer occurs when x_valid & x_ready at a rising clk edge. The payload is captured into that requester's buffer.
  - x_ready = buffer EMPTY, or buffer FULL and granted this cycle (drain-and-refill allowed).
  - The data inputs are don't-care when x_valid=0.
- Select generation at A capture:
  - JAL_en=1 gives sel=10; memToReg=1 gives sel=01; otherwise 00.
  - If both are set, JAL_en wins (sel=10) and sel_err is set. sel_err clears only on reset.
  - The selected data word is stored; the three raw inputs are not stored.
- Arbitration (combinational, on buffer state):
  - Only A FULL: grant A.
  - Only B FULL: grant B.
  - Both FULL: grant B (older load) unless starve_cnt==STARVE_MAX, in which case grant A.
  - Ordering override: if both are FULL and a_dst==b_dst, always grant B first, even at STARVE_MAX. The younger A write must land last.
- starve_cnt:
  - Increments, saturating at STARVE_MAX, each cycle both buffers are FULL and B is granted.
  - Resets to 0 whenever A is granted or A is EMPTY.
- Outputs are registered, one cycle after grant:
  - rf_wr_en=1, rf_wr_reg=granted dst, rf_wr_data=granted data.
  - wb_sel=stored sel when A is granted; holds its previous value otherwise.
  - The granted buffer goes EMPTY at the same edge.
  - Latency: request accepted at edge N, earliest rf_wr_en at edge N+1 (registered after buffer capture, i.e. visible in cycle N+2 when counted from a_valid in cycle N).
  - No grant: rf_wr_en=0; rf_wr_reg and rf_wr_data hold their previous values.
- Throughput: one write per cycle. Back-to-back A with no B sustains a_ready=1 continuously.
- rst asserted mid-operation: buffered requests are dropped, with no partial write. rf_wr_en deasserts asynchronously.

Decomposition:
- Shared package:
  - WB_SEL_ALU=2'b00, WB_SEL_MEM=2'b01, WB_SEL_PC=2'b10;
  - DATA_W and REG_AW defaults.
- One natural sub-module, wb_req_buf: a one-entry valid/ready holding register (dst, data, sel), instantiated once per requester. It is not instantiated for the select logic.
- Arbitration, starve counter and output registers stay in the top module.

Test Plan:
1. Reset, then A request: dst=3, alu=0x1234, memToReg=0, JAL_en=0 → rf_wr_en=1, reg=3, data=0x1234, wb_sel=00, one edge after capture.
2. A request with JAL_en=1, pcn=0x0042 → data=0x0042, wb_sel=10. A request with memToReg=JAL_en=1 → data=pcn, sel_err=1, and it stays 1 afterwards.
3. A (dst=2, alu=0xAAAA) and B (dst=5, data=0xBBBB) arrive in the same cycle → B written first, A the next cycle; a_ready=0 for that one cycle.
4. B held continuously valid with distinct dst, A held valid → A is granted no later than its 4th contested cycle (STARVE_MAX=3); starve_cnt returns to 0.
5. B saturated with dst=4 and A dst=4 contending at STARVE_MAX → B writes first, A after, every time; the final reg-4 value is A's data.
6. Assert rst while both buffers are FULL → rf_wr_en=0 immediately; neither write occurs after deassertion; ready signals return to 1.
